// File: rtl/alu_accumulator.sv
// ---------------------------------------------------------------------------
// alu_accumulator
//
// Purpose:
//   Sequential accumulator stage around an external combinational adder.
//   Takes one command (op + operand) over a valid/ready handshake, runs it
//   against the accumulator using the adder, then presents the new
//   accumulator value and flags on a second valid/ready handshake.
//   The flow is IDLE -> EXEC -> DONE -> IDLE, so each command takes at
//   least three cycles.
//
// Ports:
//   clk         system clock, all state on rising edge
//   rst         asynchronous, active-high reset
//   in_valid    command valid
//   in_ready    command accepted when high (IDLE only)
//   in_op       00 LOAD, 01 ADD, 10 SUB, 11 CLEAR
//   in_operand  command operand (ignored for CLEAR)
//   add_a       adder operand a (always the accumulator)
//   add_b       adder operand b (operand, or its two's complement for SUB)
//   add_result  adder sum, combinational from add_a/add_b
//   out_valid   result valid (DONE only)
//   out_ready   consumer accepts result
//   acc         accumulator value
//   carry       ADD: unsigned carry-out; SUB: borrow
//   zero        acc == 0
//
// Build option:
//   ALU_ACC_SAT_EN  when defined, ADD overflow saturates acc to all-ones and
//                   SUB borrow saturates acc to zero. When undefined,
//                   arithmetic wraps modulo 2^WIDTH.
// ---------------------------------------------------------------------------
module alu_accumulator #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [1:0]       in_op,
    input  logic [WIDTH-1:0] in_operand,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    input  logic [WIDTH-1:0] add_result,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] acc,
    output logic             carry,
    output logic             zero
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_EXEC = 2'b01,
        S_DONE = 2'b10
    } state_t;

    state_t           state_reg;
    state_t           state_next;
    logic [1:0]       op_reg;
    logic [WIDTH-1:0] operand_reg;
    logic [WIDTH-1:0] acc_reg;
    logic [WIDTH-1:0] acc_next;
    logic             carry_reg;
    logic             carry_next;
    logic             zero_reg;
    logic             zero_next;
    logic             accept;

    assign accept = in_valid && in_ready;

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // ---------------- FSM: next-state logic ----------------
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE:  if (accept) state_next = S_EXEC;
            S_EXEC:  state_next = S_DONE;
            S_DONE:  if (out_ready) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_reg)
            S_IDLE:  in_ready  = 1'b1;
            S_DONE:  out_valid = 1'b1;
            default: ;
        endcase
    end

    // ---------------- adder drive ----------------
    // Subtraction reuses the adder by feeding the two's complement of the
    // operand; SUB of 0 therefore adds 0 and leaves acc unchanged.
    assign add_a = acc_reg;
    assign add_b = (op_reg == OP_SUB) ? (~operand_reg + ONE) : operand_reg;

    // ---------------- execute-stage results ----------------
    always_comb begin
        acc_next   = acc_reg;
        carry_next = carry_reg;
        case (op_reg)
            OP_LOAD: begin
                acc_next   = operand_reg;
                carry_next = 1'b0;
            end
            OP_ADD: begin
                acc_next   = add_result;
                // Sum smaller than an addend only if it wrapped.
                carry_next = (add_result < acc_reg);
`ifdef ALU_ACC_SAT_EN
                if (carry_next) acc_next = '1;
`endif
            end
            OP_SUB: begin
                acc_next   = add_result;
                carry_next = (acc_reg < operand_reg);
`ifdef ALU_ACC_SAT_EN
                if (carry_next) acc_next = '0;
`endif
            end
            OP_CLEAR: begin
                acc_next   = '0;
                carry_next = 1'b0;
            end
            default: ;
        endcase
        zero_next = (acc_next == '0);
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_reg      <= OP_LOAD;
            operand_reg <= '0;
            acc_reg     <= '0;
            carry_reg   <= 1'b0;
            zero_reg    <= 1'b1;
        end else begin
            if (state_reg == S_IDLE && accept) begin
                op_reg      <= in_op;
                operand_reg <= in_operand;
            end
            // add_result is only trusted here, one cycle after the operands
            // were captured, so the adder has settled.
            if (state_reg == S_EXEC) begin
                acc_reg   <= acc_next;
                carry_reg <= carry_next;
                zero_reg  <= zero_next;
            end
        end
    end

    assign acc   = acc_reg;
    assign carry = carry_reg;
    assign zero  = zero_reg;

endmodule

// File: tb/tb_alu_accumulator.sv
module tb_alu_accumulator;

    localparam int W = 8;

    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [1:0]   in_op;
    logic [W-1:0] in_operand;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic [W-1:0] add_result;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] acc;
    logic         carry;
    logic         zero;

    int n_cmp  = 0;
    int n_fail = 0;

    // Combinational adder the block is wrapped around.
    assign add_result = add_a + add_b;

    alu_accumulator #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_op      (in_op),
        .in_operand (in_operand),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_result (add_result),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .acc        (acc),
        .carry      (carry),
        .zero       (zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [1:0] LOAD  = 2'b00;
    localparam logic [1:0] ADD   = 2'b01;
    localparam logic [1:0] SUB   = 2'b10;
    localparam logic [1:0] CLEAR = 2'b11;

    typedef struct {
        string        name;
        logic [1:0]   op;
        logic [W-1:0] operand;
        logic [W-1:0] exp_acc;
        logic         exp_carry;
        logic         exp_zero;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Wait for in_ready, present the command, check the EXEC/DONE timing and
    // leave the block sitting in DONE with out_ready low.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] operand);
        @(negedge clk);
        for (int k = 0; k < 20 && !in_ready; k++) @(negedge clk);
        check("in_ready_wait", {31'd0, in_ready}, 32'd1);
        in_valid   = 1'b1;
        in_op      = op;
        in_operand = operand;
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("exec_out_valid", {31'd0, out_valid}, 32'd0);
        check("exec_in_ready", {31'd0, in_ready}, 32'd0);
        @(negedge clk);
        check("done_out_valid", {31'd0, out_valid}, 32'd1);
    endtask

    // Complete the output handshake; the block must be ready again next cycle.
    task automatic release_out();
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("ready_after_done", {31'd0, in_ready}, 32'd1);
        check("valid_after_done", {31'd0, out_valid}, 32'd0);
    endtask

    task automatic run_vec(input int idx, input vec_t v);
        issue(v.op, v.operand);
        check({v.name, "_acc"},   {24'd0, acc},   {24'd0, v.exp_acc});
        check({v.name, "_carry"}, {31'd0, carry}, {31'd0, v.exp_carry});
        check({v.name, "_zero"},  {31'd0, zero},  {31'd0, v.exp_zero});
        $display("txn %0d %s op=%0d operand=%02h -> acc=%02h carry=%0b zero=%0b",
                 idx, v.name, v.op, v.operand, acc, carry, zero);
        release_out();
    endtask

    initial begin
        int pulses;
        vec_t v;

`ifdef ALU_ACC_SAT_EN
        vecs[3]  = '{"add_ovf",  ADD,   8'h01, 8'hFF, 1'b1, 1'b0};
        vecs[5]  = '{"sub_brw",  SUB,   8'h06, 8'h00, 1'b1, 1'b1};
        vecs[11] = '{"add_ovf2", ADD,   8'hD0, 8'hFF, 1'b1, 1'b0};
`else
        vecs[3]  = '{"add_ovf",  ADD,   8'h01, 8'h00, 1'b1, 1'b1};
        vecs[5]  = '{"sub_brw",  SUB,   8'h06, 8'hFF, 1'b1, 1'b0};
        vecs[11] = '{"add_ovf2", ADD,   8'hD0, 8'h00, 1'b1, 1'b1};
`endif
        vecs[0]  = '{"load7f",   LOAD,  8'h7F, 8'h7F, 1'b0, 1'b0};
        vecs[1]  = '{"add1",     ADD,   8'h01, 8'h80, 1'b0, 1'b0};
        vecs[2]  = '{"loadff",   LOAD,  8'hFF, 8'hFF, 1'b0, 1'b0};
        vecs[4]  = '{"load05",   LOAD,  8'h05, 8'h05, 1'b0, 1'b0};
        vecs[6]  = '{"load05b",  LOAD,  8'h05, 8'h05, 1'b0, 1'b0};
        vecs[7]  = '{"sub0",     SUB,   8'h00, 8'h05, 1'b0, 1'b0};
        vecs[8]  = '{"clear",    CLEAR, 8'hAA, 8'h00, 1'b0, 1'b1};
        vecs[9]  = '{"add3c",    ADD,   8'h3C, 8'h3C, 1'b0, 1'b0};
        vecs[10] = '{"sub0c",    SUB,   8'h0C, 8'h30, 1'b0, 1'b0};

        rst        = 1'b1;
        in_valid   = 1'b0;
        in_op      = LOAD;
        in_operand = '0;
        out_ready  = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_acc",       {24'd0, acc},       32'h00);
        check("rst_carry",     {31'd0, carry},     32'd0);
        check("rst_zero",      {31'd0, zero},      32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_in_ready",  {31'd0, in_ready},  32'd1);

        // Mid-cycle reset while a result is held in DONE.
        issue(LOAD, 8'h5A);
        check("pre_rst_acc", {24'd0, acc}, 32'h5A);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_rst_acc",       {24'd0, acc},       32'h00);
        check("async_rst_carry",     {31'd0, carry},     32'd0);
        check("async_rst_zero",      {31'd0, zero},      32'd1);
        check("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_in_ready", {31'd0, in_ready}, 32'd1);
        $display("txn reset mid-cycle -> acc=%02h zero=%0b", acc, zero);

        for (int i = 0; i < 12; i++) begin
            v = vecs[i];
            run_vec(i, v);
        end

        // Backpressure: result held while a new ADD is pending on the input.
        issue(LOAD, 8'h20);
        out_ready  = 1'b0;
        in_valid   = 1'b1;
        in_op      = ADD;
        in_operand = 8'h10;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_acc",       {24'd0, acc},       32'h20);
            check("bp_carry",     {31'd0, carry},     32'd0);
            check("bp_zero",      {31'd0, zero},      32'd0);
            check("bp_out_valid", {31'd0, out_valid}, 32'd1);
            check("bp_in_ready",  {31'd0, in_ready},  32'd0);
        end
        $display("txn backpressure hold 5 cycles acc=%02h", acc);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        @(negedge clk);
        check("bp_ready_after", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        check("bp_exec_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        check("bp_done_valid", {31'd0, out_valid}, 32'd1);
        check("bp_add_acc",    {24'd0, acc},       32'h30);
        $display("txn backpressure ADD 10 -> acc=%02h", acc);
        release_out();
        repeat (3) @(negedge clk);
        check("bp_single_accept_acc", {24'd0, acc},      32'h30);
        check("bp_idle_in_ready",     {31'd0, in_ready}, 32'd1);

        // Abort: reset while CLEAR is in EXEC, no out_valid for it.
        v = '{"abort_load33", LOAD, 8'h33, 8'h33, 1'b0, 1'b0};
        run_vec(100, v);
        @(negedge clk);
        in_valid   = 1'b1;
        in_op      = CLEAR;
        in_operand = 8'h00;
        @(posedge clk);
        #1 in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        check("abort_acc",       {24'd0, acc},       32'h00);
        check("abort_zero",      {31'd0, zero},      32'd1);
        check("abort_out_valid", {31'd0, out_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (out_valid) pulses++;
        end
        check("abort_no_valid", pulses, 0);
        $display("txn abort CLEAR in EXEC -> acc=%02h zero=%0b", acc, zero);
        v = '{"after_abort_load42", LOAD, 8'h42, 8'h42, 1'b0, 1'b0};
        run_vec(101, v);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
